// File: rtl/peripheral_dbg_pu_msp430_dbg_arbiter.sv
// Arbitrates the MSP430 debug register port between UART (A) and I2C (B) front-ends; accesses forwarded one cycle after the strobe.
// No backpressure: non-owner requests are dropped and counted. Ownership is held across bursts, pending reads and an idle window.
module peripheral_dbg_pu_msp430_dbg_arbiter #(
    parameter int unsigned HOLD_CYCLES = 255
) (
    input  logic        i_dbg_clk,
    input  logic        i_dbg_rst,
    input  logic        i_a_en,
    input  logic [5:0]  i_a_addr,
    input  logic [15:0] i_a_din,
    input  logic        i_a_wr,
    input  logic        i_a_rd,
    output logic        o_a_rd_rdy,
    output logic        o_a_gnt,
    input  logic        i_b_en,
    input  logic [5:0]  i_b_addr,
    input  logic [15:0] i_b_din,
    input  logic        i_b_wr,
    input  logic        i_b_rd,
    output logic        o_b_rd_rdy,
    output logic        o_b_gnt,
    output logic [5:0]  o_dbg_addr,
    output logic [15:0] o_dbg_din,
    output logic        o_dbg_wr,
    output logic        o_dbg_rd,
    input  logic        i_dbg_rd_rdy,
    input  logic        i_mem_burst,
    output logic [1:0]  o_owner,
    output logic [7:0]  o_drop_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    localparam logic [7:0] HOLD_LOAD = HOLD_CYCLES[7:0];

    state_t      r_state;
    logic        r_last_b;
    logic [7:0]  r_hold;
    logic        r_rd_pend;
    logic [5:0]  r_dbg_addr;
    logic [15:0] r_dbg_din;
    logic        r_dbg_wr;
    logic        r_dbg_rd;
    logic [7:0]  r_drop_cnt;

    logic        w_req_a;
    logic        w_req_b;
    logic        w_active;
    logic        w_sel_b;
    logic        w_sel_en;
    logic        w_sel_wr;
    logic        w_sel_rd;
    logic [5:0]  w_sel_addr;
    logic [15:0] w_sel_din;
    logic        w_fwd;
    logic        w_other;
    logic        w_drop;
    logic        w_own_dis;
    logic        w_run;
    logic        w_release;
    logic        w_issue_rd;

    always_comb begin
        w_req_a  = i_a_en & (i_a_wr | i_a_rd);
        w_req_b  = i_b_en & (i_b_wr | i_b_rd);
        w_active = (r_state == OWN_A) | (r_state == OWN_B);

        // In IDLE under contention, the port that did not own last time wins.
        w_sel_b = 1'b0;
        case (r_state)
            OWN_A:   w_sel_b = 1'b0;
            OWN_B:   w_sel_b = 1'b1;
            default: w_sel_b = w_req_b & (~w_req_a | ~r_last_b);
        endcase

        w_sel_en   = w_sel_b ? i_b_en   : i_a_en;
        w_sel_wr   = w_sel_b ? i_b_wr   : i_a_wr;
        w_sel_rd   = w_sel_b ? i_b_rd   : i_a_rd;
        w_sel_addr = w_sel_b ? i_b_addr : i_a_addr;
        w_sel_din  = w_sel_b ? i_b_din  : i_a_din;

        w_fwd      = w_sel_b ? w_req_b : w_req_a;
        w_other    = w_sel_b ? w_req_a : w_req_b;
        w_drop     = w_other | (w_fwd & w_sel_wr & w_sel_rd);
        w_issue_rd = w_fwd & w_sel_rd & ~w_sel_wr;

        w_own_dis  = w_active & ~w_sel_en;
        w_run      = (r_hold != 8'd0) & ~i_mem_burst & ~r_rd_pend;
        w_release  = w_active & (~w_sel_en |
                     (~w_fwd & (r_hold == 8'd0) & ~i_mem_burst & ~r_rd_pend));
    end

    always_ff @(posedge i_dbg_clk or posedge i_dbg_rst) begin
        if (i_dbg_rst) begin
            r_state    <= IDLE;
            r_last_b   <= 1'b1;
            r_hold     <= 8'd0;
            r_rd_pend  <= 1'b0;
            r_dbg_addr <= 6'h00;
            r_dbg_din  <= 16'h0000;
            r_dbg_wr   <= 1'b0;
            r_dbg_rd   <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_dbg_wr <= w_fwd & w_sel_wr;
            r_dbg_rd <= w_issue_rd;
            if (w_fwd) begin
                r_dbg_addr <= w_sel_addr;
            end
            if (w_fwd & w_sel_wr) begin
                r_dbg_din <= w_sel_din;
            end

            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end

            // Disabling the owner abandons its read so a late return goes nowhere.
            if (w_own_dis) begin
                r_rd_pend <= 1'b0;
            end else if (w_issue_rd) begin
                r_rd_pend <= 1'b1;
            end else if (i_dbg_rd_rdy) begin
                r_rd_pend <= 1'b0;
            end

            if (w_fwd) begin
                r_hold <= HOLD_LOAD;
            end else if (w_own_dis) begin
                r_hold <= 8'd0;
            end else if (w_run) begin
                r_hold <= r_hold - 8'd1;
            end

            case (r_state)
                IDLE: begin
                    if (w_fwd) begin
                        r_state <= w_sel_b ? OWN_B : OWN_A;
                    end
                end
                OWN_A, OWN_B: begin
                    if (w_release) begin
                        r_state  <= IDLE;
                        r_last_b <= (r_state == OWN_B);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_owner    = r_state;
    assign o_a_gnt    = (r_state == OWN_A);
    assign o_b_gnt    = (r_state == OWN_B);
    assign o_a_rd_rdy = i_dbg_rd_rdy & r_rd_pend & (r_state == OWN_A);
    assign o_b_rd_rdy = i_dbg_rd_rdy & r_rd_pend & (r_state == OWN_B);
    assign o_dbg_addr = r_dbg_addr;
    assign o_dbg_din  = r_dbg_din;
    assign o_dbg_wr   = r_dbg_wr;
    assign o_dbg_rd   = r_dbg_rd;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_peripheral_dbg_pu_msp430_dbg_arbiter.sv
// Directed bench for the debug port arbiter with a 4-cycle hold window.
module tb_peripheral_dbg_pu_msp430_dbg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, a_wr, a_rd, b_en, b_wr, b_rd;
    logic [5:0]  a_addr, b_addr;
    logic [15:0] a_din, b_din;
    logic        a_rd_rdy, b_rd_rdy, a_gnt, b_gnt;
    logic [5:0]  dbg_addr;
    logic [15:0] dbg_din;
    logic        dbg_wr, dbg_rd, dbg_rd_rdy, mem_burst;
    logic [1:0]  owner;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    peripheral_dbg_pu_msp430_dbg_arbiter #(.HOLD_CYCLES(4)) dut (
        .i_dbg_clk    (clk),
        .i_dbg_rst    (rst),
        .i_a_en       (a_en),
        .i_a_addr     (a_addr),
        .i_a_din      (a_din),
        .i_a_wr       (a_wr),
        .i_a_rd       (a_rd),
        .o_a_rd_rdy   (a_rd_rdy),
        .o_a_gnt      (a_gnt),
        .i_b_en       (b_en),
        .i_b_addr     (b_addr),
        .i_b_din      (b_din),
        .i_b_wr       (b_wr),
        .i_b_rd       (b_rd),
        .o_b_rd_rdy   (b_rd_rdy),
        .o_b_gnt      (b_gnt),
        .o_dbg_addr   (dbg_addr),
        .o_dbg_din    (dbg_din),
        .o_dbg_wr     (dbg_wr),
        .o_dbg_rd     (dbg_rd),
        .i_dbg_rd_rdy (dbg_rd_rdy),
        .i_mem_burst  (mem_burst),
        .o_owner      (owner),
        .o_drop_cnt   (drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_owner"}, {14'd0, owner}, 16'h0);
        chk({tag, "_gnt"}, {14'd0, a_gnt, b_gnt}, 16'h0);
        chk({tag, "_addr"}, {10'd0, dbg_addr}, 16'h0);
        chk({tag, "_din"}, dbg_din, 16'h0);
        chk({tag, "_wrrd"}, {14'd0, dbg_wr, dbg_rd}, 16'h0);
        chk({tag, "_rdrdy"}, {14'd0, a_rd_rdy, b_rd_rdy}, 16'h0);
        chk({tag, "_drop"}, {8'd0, drop_cnt}, 16'h0);
    endtask

    initial begin
        rst = 1'b1;
        a_en = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_addr = 6'h00; a_din = 16'h0;
        b_en = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_addr = 6'h00; b_din = 16'h0;
        dbg_rd_rdy = 1'b0; mem_burst = 1'b0;
        tick();
        tick();
        chk_reset_outputs("rst0");
        rst = 1'b0;

        // Single write from A
        a_en = 1'b1; b_en = 1'b1;
        a_wr = 1'b1; a_addr = 6'h05; a_din = 16'hA55A;
        tick();
        a_wr = 1'b0;
        chk("wr1_dbg_wr", {15'd0, dbg_wr}, 16'h1);
        chk("wr1_addr", {10'd0, dbg_addr}, 16'h0005);
        chk("wr1_din", dbg_din, 16'hA55A);
        chk("wr1_gnt", {14'd0, a_gnt, b_gnt}, 16'h2);
        chk("wr1_owner", {14'd0, owner}, 16'h1);
        tick();
        chk("wr1_pulse_end", {15'd0, dbg_wr}, 16'h0);
        chk("wr1_addr_hold", {10'd0, dbg_addr}, 16'h0005);
        tick(); tick(); tick();
        chk("wr1_hold_owner", {14'd0, owner}, 16'h1);
        tick();
        chk("wr1_release", {14'd0, owner}, 16'h0);

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Contention from IDLE after reset: A wins
        a_rd = 1'b1; a_addr = 6'h11;
        b_rd = 1'b1; b_addr = 6'h22;
        tick();
        a_rd = 1'b0; b_rd = 1'b0;
        chk("ct1_owner", {14'd0, owner}, 16'h1);
        chk("ct1_gnt", {14'd0, a_gnt, b_gnt}, 16'h2);
        chk("ct1_dbg_rd", {15'd0, dbg_rd}, 16'h1);
        chk("ct1_addr", {10'd0, dbg_addr}, 16'h0011);
        chk("ct1_drop", {8'd0, drop_cnt}, 16'h1);
        tick();
        dbg_rd_rdy = 1'b1;
        #1;
        chk("ct1_rdrdy", {14'd0, a_rd_rdy, b_rd_rdy}, 16'h2);
        tick();
        dbg_rd_rdy = 1'b0;
        tick(); tick(); tick(); tick();
        chk("ct1_hold_owner", {14'd0, owner}, 16'h1);
        tick();
        chk("ct1_release", {14'd0, owner}, 16'h0);

        // Second contention: B wins round-robin
        a_wr = 1'b1; a_addr = 6'h30; a_din = 16'h1111;
        b_wr = 1'b1; b_addr = 6'h31; b_din = 16'h2222;
        tick();
        a_wr = 1'b0; b_wr = 1'b0;
        chk("ct2_owner", {14'd0, owner}, 16'h2);
        chk("ct2_gnt", {14'd0, a_gnt, b_gnt}, 16'h1);
        chk("ct2_dbg_wr", {15'd0, dbg_wr}, 16'h1);
        chk("ct2_addr", {10'd0, dbg_addr}, 16'h0031);
        chk("ct2_din", dbg_din, 16'h2222);
        chk("ct2_drop", {8'd0, drop_cnt}, 16'h2);

        // Read routing to B
        b_rd = 1'b1; b_addr = 6'h07;
        tick();
        b_rd = 1'b0;
        chk("rr_dbg_rd", {14'd0, dbg_wr, dbg_rd}, 16'h1);
        chk("rr_addr", {10'd0, dbg_addr}, 16'h0007);
        tick();
        tick();
        dbg_rd_rdy = 1'b1;
        #1;
        chk("rr_rdrdy", {14'd0, a_rd_rdy, b_rd_rdy}, 16'h1);
        tick();
        dbg_rd_rdy = 1'b0;
        tick();
        dbg_rd_rdy = 1'b1;
        #1;
        chk("rr_stray", {14'd0, a_rd_rdy, b_rd_rdy}, 16'h0);
        chk("rr_owner", {14'd0, owner}, 16'h2);
        dbg_rd_rdy = 1'b0;
        tick(); tick(); tick();
        chk("rr_hold_owner", {14'd0, owner}, 16'h2);
        tick();
        chk("rr_release", {14'd0, owner}, 16'h0);

        // Hold window frozen by a burst; B request in the release cycle is dropped
        a_wr = 1'b1; a_addr = 6'h01; a_din = 16'h0001; mem_burst = 1'b1;
        tick();
        a_wr = 1'b0;
        chk("hb_owner_n1", {14'd0, owner}, 16'h1);
        repeat (8) tick();
        chk("hb_owner_n9", {14'd0, owner}, 16'h1);
        tick();
        mem_burst = 1'b0;
        tick(); tick(); tick();
        chk("hb_owner_n13", {14'd0, owner}, 16'h1);
        tick();
        b_wr = 1'b1; b_addr = 6'h03;
        chk("hb_owner_n14", {14'd0, owner}, 16'h1);
        tick();
        b_wr = 1'b0;
        chk("hb_idle_n15", {14'd0, owner}, 16'h0);
        chk("hb_gnt", {14'd0, a_gnt, b_gnt}, 16'h0);
        chk("hb_no_fwd", {15'd0, dbg_wr}, 16'h0);
        chk("hb_drop", {8'd0, drop_cnt}, 16'h3);

        // Disable owner with a read pending
        a_rd = 1'b1; a_addr = 6'h09;
        tick();
        a_rd = 1'b0;
        chk("dis_owner", {14'd0, owner}, 16'h1);
        chk("dis_dbg_rd", {15'd0, dbg_rd}, 16'h1);
        tick();
        a_en = 1'b0;
        tick();
        chk("dis_release", {14'd0, owner}, 16'h0);
        tick();
        dbg_rd_rdy = 1'b1;
        #1;
        chk("dis_late_rdy", {14'd0, a_rd_rdy, b_rd_rdy}, 16'h0);
        a_en = 1'b1;

        // Drop counter saturation while A holds the grant through a burst
        a_wr = 1'b1; a_addr = 6'h02; a_din = 16'hBEEF;
        tick();
        dbg_rd_rdy = 1'b0;
        a_wr = 1'b0; mem_burst = 1'b1; b_wr = 1'b1; b_addr = 6'h04;
        chk("sat_owner", {14'd0, owner}, 16'h1);
        chk("sat_din", dbg_din, 16'hBEEF);
        repeat (10) tick();
        chk("sat_drop13", {8'd0, drop_cnt}, 16'h000D);
        repeat (241) tick();
        chk("sat_dropFE", {8'd0, drop_cnt}, 16'h00FE);
        tick();
        chk("sat_dropFF", {8'd0, drop_cnt}, 16'h00FF);
        repeat (48) tick();
        chk("sat_hold_FF", {8'd0, drop_cnt}, 16'h00FF);
        chk("sat_owner_end", {14'd0, owner}, 16'h1);
        b_wr = 1'b0;

        // Reset with a read pending
        a_rd = 1'b1; a_addr = 6'h3F;
        tick();
        a_rd = 1'b0;
        chk("rp_dbg_rd", {15'd0, dbg_rd}, 16'h1);
        rst = 1'b1;
        dbg_rd_rdy = 1'b1;
        #1;
        chk_reset_outputs("rst1");
        tick();
        rst = 1'b0;
        mem_burst = 1'b0;
        #1;
        chk("rst1_lost_rd", {14'd0, a_rd_rdy, b_rd_rdy}, 16'h0);
        dbg_rd_rdy = 1'b0;
        a_wr = 1'b1; b_wr = 1'b1;
        tick();
        a_wr = 1'b0; b_wr = 1'b0;
        chk("rst1_rr_owner", {14'd0, owner}, 16'h1);
        chk("rst1_rr_drop", {8'd0, drop_cnt}, 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
